// File: rtl/nios2_cpu_mulx_seq.sv
// Iterative 32x32 multiplier: four 16x16 partial products through one registered
// multiplier, 64-bit accumulation, signed correction, low or high word returned.
module nios2_cpu_mulx_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mul_op,
  input  logic [DATA_W-1:0] mul_src1,
  input  logic [DATA_W-1:0] mul_src2,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mul_result,
  output logic [2:0]        o_dbg_state
);

  localparam int HALF_W = DATA_W / 2;
  localparam int ACC_W  = 2 * DATA_W;

  // Handshake: start is accepted only on a cycle where busy=0 and kill=0;
  // done pulses for one cycle with mul_result valid and held until the next done.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ACC   = 3'd2,
    S_CORR  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_cnt;
  logic [1:0]         r_op;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_mult;
  logic [ACC_W-1:0]   r_acc;
  logic [DATA_W-1:0]  r_result;

  logic               w_accept;
  logic [HALF_W-1:0]  w_pp_a;
  logic [HALF_W-1:0]  w_pp_b;
  logic [DATA_W-1:0]  w_pp;
  logic               w_acc_en;
  logic [5:0]         w_shift;
  logic [ACC_W-1:0]   w_addend;
  logic [ACC_W-1:0]   w_corr_a;
  logic [ACC_W-1:0]   w_corr_b;
  logic [ACC_W-1:0]   w_acc_corr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ISSUE;
      S_ISSUE: if (r_cnt == 2'd3) w_state_nxt = S_ACC;
      S_ACC:   w_state_nxt = S_CORR;
      S_CORR:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (kill) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  assign w_accept = (r_state == S_IDLE) && start && !kill;

  // cnt bit 0 picks the A half, bit 1 the B half: lo*lo, hi*lo, lo*hi, hi*hi.
  assign w_pp_a = r_cnt[0] ? r_a[DATA_W-1:HALF_W] : r_a[HALF_W-1:0];
  assign w_pp_b = r_cnt[1] ? r_b[DATA_W-1:HALF_W] : r_b[HALF_W-1:0];
  assign w_pp   = DATA_W'(w_pp_a) * DATA_W'(w_pp_b);

  // r_mult lags issue by one cycle, so the shift belongs to product cnt-1.
  assign w_acc_en = ((r_state == S_ISSUE) && (r_cnt != 2'd0)) || (r_state == S_ACC);
  always_comb begin
    w_shift = 6'd16;
    if (r_state == S_ACC)     w_shift = 6'd32;
    else if (r_cnt == 2'd1)   w_shift = 6'd0;
  end
  assign w_addend = {{DATA_W{1'b0}}, r_mult} << w_shift;

  assign w_corr_a   = (r_op[1] && r_a[DATA_W-1]) ? {r_b, {DATA_W{1'b0}}} : '0;
  assign w_corr_b   = ((r_op == 2'b11) && r_b[DATA_W-1]) ? {r_a, {DATA_W{1'b0}}} : '0;
  assign w_acc_corr = r_acc - w_corr_a - w_corr_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mult   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= mul_op;
        r_a   <= mul_src1;
        r_b   <= mul_src2;
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        if (r_state == S_ISSUE) begin
          r_mult <= w_pp;
          r_cnt  <= r_cnt + 2'd1;
        end
        if (w_acc_en) r_acc <= r_acc + w_addend;
        if ((r_state == S_CORR) && !kill) begin
          r_acc    <= w_acc_corr;
          r_result <= (r_op == 2'b00) ? w_acc_corr[DATA_W-1:0] : w_acc_corr[ACC_W-1:DATA_W];
        end
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mul_result  = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nios2_cpu_mulx_seq.sv
// Bench for nios2_cpu_mulx_seq: directed corner ops, kill/reset aborts and
// randomized ops checked against a wide-arithmetic reference.
module tb_nios2_cpu_mulx_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  mul_op;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] mul_result;
  logic [2:0]  o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  nios2_cpu_mulx_seq #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mul_op(mul_op),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .kill(kill), .busy(busy),
    .done(done), .mul_result(mul_result), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    sa = op[1]          ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
    sb = (op == 2'b11)  ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'(1) << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  // driver: one operation from accept to the cycle after done
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noisy);
    int lat, busy_cnt;
    logic [31:0] exp;
    @(negedge clk);
    start = 1'b1; mul_op = op; mul_src1 = a; mul_src2 = b;
    exp_q.push_back(ref_mul(op, a, b));
    @(negedge clk);
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        mul_op = 2'($urandom_range(0, 3));
        mul_src1 = $urandom; mul_src2 = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    exp = exp_q.pop_front();
    check("latency", lat, 7);
    check("busy_cycles", busy_cnt, 7);
    check($sformatf("result op%0d a=%h b=%h", op, a, b), mul_result, exp);
    last_res = exp;
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_single_pulse", done, 0);
    check("result_hold", mul_result, exp);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) hits++;
    end
    check(tag, hits, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; kill = 1'b0; mul_op = '0;
    mul_src1 = '0; mul_src2 = '0; last_res = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", mul_result, 0);
    reset_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("t1_value", last_res, 32'hFFFF_FFFE);
    run_op(2'b00, 32'h0001_2345, 32'h0001_0000, 0);
    check("t2_mul_value", last_res, 32'h2345_0000);
    run_op(2'b01, 32'h0001_2345, 32'h0001_0000, 0);
    run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h0000_0002, 32'h8000_0000, 0);

    // kill in the third cycle of an op
    @(negedge clk);
    start = 1'b1; mul_op = 2'b01; mul_src1 = 32'h1234_5678; mul_src2 = 32'h9ABC_DEF0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    check("kill_busy", busy, 0);
    check("kill_result_held", mul_result, last_res);
    watch_no_done("kill_no_done", 10);
    check("kill_result_still_held", mul_result, last_res);
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 0);

    // kill together with start in idle drops the start
    @(negedge clk); start = 1'b1; kill = 1'b1;
    @(negedge clk); start = 1'b0; kill = 1'b0;
    check("kill_start_busy", busy, 0);
    watch_no_done("kill_start_no_done", 9);

    // reset mid-operation
    @(negedge clk);
    start = 1'b1; mul_op = 2'b11; mul_src1 = $urandom; mul_src2 = $urandom;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_result", mul_result, 0);
    @(negedge clk); reset_n = 1'b1;
    last_res = '0;
    watch_no_done("rst_mid_no_done", 10);

    // randomized ops with noisy inputs while busy
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
